// File: rtl/fifo_access_scheduler_if.sv
// Bundle between the producers, the consumer and the shared FIFO
// controls driven by the access scheduler.
interface fifo_access_scheduler_if #(
  parameter int FIFO_WIDTH     = 16,
  parameter int NO_OF_ELEMENTS = 16,
  parameter int NUM_REQ        = 4,
  parameter int CNT_W          = $clog2(NO_OF_ELEMENTS + 1)
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          rd_req;
  logic                          rd_valid;
  logic                          fifo_resetn;
  logic                          fifo_w_en;
  logic [FIFO_WIDTH-1:0]         fifo_d_in;
  logic                          fifo_r_en;
  logic [CNT_W-1:0]              occupancy;
  logic                          full;
  logic                          empty;

  modport master (
    output req, req_data, rd_req,
    input  ack, rd_valid, fifo_resetn, fifo_w_en,
    input  fifo_d_in, fifo_r_en, occupancy, full, empty
  );

  modport slave (
    input  req, req_data, rd_req,
    output ack, rd_valid, fifo_resetn, fifo_w_en,
    output fifo_d_in, fifo_r_en, occupancy, full, empty
  );
endinterface

// File: rtl/fifo_access_scheduler.sv
// Round-robin write arbiter and occupancy tracker in front of a
// status-less synchronous FIFO shared by NUM_REQ producers.
module fifo_access_scheduler #(
  parameter int FIFO_WIDTH     = 16,
  parameter int NO_OF_ELEMENTS = 16,
  parameter int NUM_REQ        = 4,
  parameter int CNT_W          = $clog2(NO_OF_ELEMENTS + 1),
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic reset,
  fifo_access_scheduler_if.slave bus
);

  logic [CNT_W-1:0]      r_count;
  logic [IDX_W-1:0]      r_last_grant;
  logic                  r_rd_valid;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_go;
  logic                  w_rd_go;
  logic [IDX_W-1:0]      w_win;
  logic [NUM_REQ-1:0]    w_ack;
  logic [FIFO_WIDTH-1:0] w_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_data[g] = bus.req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  assign w_full  = (r_count == CNT_W'(NO_OF_ELEMENTS));
  assign w_empty = (r_count == '0);

  // Reset gates the go signals so no ack or enable leaks out
  // while the FIFO is being cleared.
  assign w_wr_go = (|bus.req) & ~w_full & ~reset;
  assign w_rd_go = bus.rd_req & ~w_empty & ~reset;

  // Scan from the farthest slot down to the nearest so the first
  // requester after last_grant is the final (winning) assignment.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    v_idx = '0;
    w_win = r_last_grant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      v_idx = IDX_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (bus.req[v_idx]) w_win = v_idx;
    end
  end

  // One-hot ack for the winner, only when the write really happens.
  always_comb begin
    w_ack = '0;
    if (w_wr_go) w_ack[w_win] = 1'b1;
  end

  // Count, priority pointer and read-valid pipeline flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_go;
      if (w_wr_go) r_last_grant <= w_win;
      if (w_wr_go && !w_rd_go) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_wr_go && w_rd_go) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign bus.ack         = w_ack;
  assign bus.fifo_w_en   = w_wr_go;
  assign bus.fifo_d_in   = w_wr_go ? w_data[w_win] : '0;
  assign bus.fifo_r_en   = w_rd_go;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.fifo_resetn = ~reset;
  assign bus.occupancy   = r_count;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed plus random bench for fifo_access_scheduler, with a
// queue-based reference model and a behavioural FIFO stand-in.
module tb_fifo_access_scheduler;
  localparam int W = 16;
  localparam int E = 16;
  localparam int N = 4;
  localparam int C = $clog2(E + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;

  int total = 0;
  int bad = 0;
  int n_ack = 0;
  int n_rv = 0;

  fifo_access_scheduler_if #(
    .FIFO_WIDTH(W), .NO_OF_ELEMENTS(E), .NUM_REQ(N), .CNT_W(C)
  ) bus ();

  fifo_access_scheduler #(
    .FIFO_WIDTH(W), .NO_OF_ELEMENTS(E), .NUM_REQ(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared synchronous FIFO.
  logic [W-1:0] fmem [$];
  logic [W-1:0] d_out;
  always @(posedge clk or negedge bus.fifo_resetn) begin
    logic [W-1:0] t;
    if (!bus.fifo_resetn) begin
      fmem.delete();
      d_out <= '0;
    end else begin
      if (bus.fifo_r_en && fmem.size() > 0) begin
        t = fmem.pop_front();
        d_out <= t;
      end
      if (bus.fifo_w_en) fmem.push_back(bus.fifo_d_in);
    end
  end

  // Reference model state.
  int m_cnt;
  int m_last;
  logic [W-1:0] m_q [$];
  bit m_rv;
  logic [W-1:0] m_rd;
  logic [W-1:0] pdata [N];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0;
    m_last = N - 1;
    m_q.delete();
    m_rv = 0;
    m_rd = '0;
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model.
  task automatic step(logic [N-1:0] rq, logic rr);
    int j;
    bit wr;
    bit rd;
    logic [N-1:0] e_ack;
    logic [W-1:0] e_din;
    bus.req = rq;
    bus.rd_req = rr;
    bus.req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};
    #3;
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    if (m_rv) chk("rd_data", 32'(d_out), 32'(m_rd));
    if (bus.rd_valid) n_rv++;
    if (bus.ack != '0) n_ack++;
    j = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (rq[c] && j < 0) j = c;
    end
    wr = (j >= 0) && (m_cnt < E);
    rd = rr && (m_cnt > 0);
    e_ack = '0;
    e_din = '0;
    if (wr) begin
      e_ack[j] = 1'b1;
      e_din = pdata[j];
    end
    chk("ack", 32'(bus.ack), 32'(e_ack));
    chk("w_en", 32'(bus.fifo_w_en), 32'(wr));
    chk("d_in", 32'(bus.fifo_d_in), 32'(e_din));
    chk("r_en", 32'(bus.fifo_r_en), 32'(rd));
    chk("occ", 32'(bus.occupancy), 32'(m_cnt));
    chk("full", 32'(bus.full), 32'(m_cnt == E));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    @(posedge clk);
    #1;
    m_rv = rd;
    if (rd) m_rd = m_q.pop_front();
    if (wr) begin
      m_q.push_back(pdata[j]);
      m_last = j;
    end
    m_cnt = m_cnt + int'(wr) - int'(rd);
  endtask

  initial begin
    int a0;
    int v0;
    bus.req = '0;
    bus.rd_req = 1'b0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) pdata[i] = W'(16'h1000 + i);
    m_reset();

    // Reset and idle
    #12;
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_rv", 32'(bus.rd_valid), 0);
    chk("rst_resetn", 32'(bus.fifo_resetn), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rel_resetn", 32'(bus.fifo_resetn), 1);
    step('0, 1'b0);
    step('0, 1'b0);

    // Round robin, all requesting
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b0);
      chk("rr_order", 32'(m_last), 32'(i % N));
    end
    chk("occ8", 32'(bus.occupancy), 8);
    for (int i = 0; i < 8; i++) step('0, 1'b1);
    step('0, 1'b0);

    // Fill to full and hold requests
    for (int i = 0; i < E; i++) step(4'b1111, 1'b0);
    chk("full16", 32'(bus.full), 1);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    chk("full_rd_occ", 32'(bus.occupancy), 15);
    step(4'b1111, 1'b0);
    chk("refill_occ", 32'(bus.occupancy), 16);

    // Drain, then write+read at empty
    while (m_cnt > 0) step('0, 1'b1);
    step('0, 1'b0);
    pdata[2] = 16'hBEEF;
    step(4'b0100, 1'b1);
    chk("empty_occ", 32'(bus.occupancy), 1);
    step('0, 1'b0);
    step('0, 1'b1);
    step('0, 1'b0);
    chk("empty_data", 32'(d_out), 32'h0000BEEF);

    // Sustained traffic at occupancy 5
    while (m_cnt < 5) step(4'b0001, 1'b0);
    a0 = n_ack;
    v0 = n_rv;
    for (int i = 0; i < 20; i++) step(4'b0001, 1'b1);
    step('0, 1'b0);
    chk("sus_acks", 32'(n_ack - a0), 20);
    chk("sus_rv", 32'(n_rv - v0), 20);
    chk("sus_occ", 32'(bus.occupancy), 5);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < N; p++) pdata[p] = W'($urandom);
      step(N'($urandom_range(0, 15)), 1'($urandom % 2));
    end
    step('0, 1'b0);

    // Mid-operation asynchronous reset at occupancy 9
    while (m_cnt > 9) step('0, 1'b1);
    while (m_cnt < 9) step(4'b1111, 1'b0);
    step('0, 1'b0);
    chk("pre_rst_occ", 32'(bus.occupancy), 9);
    bus.req = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_occ", 32'(bus.occupancy), 0);
    chk("mrst_ack", 32'(bus.ack), 0);
    chk("mrst_wen", 32'(bus.fifo_w_en), 0);
    chk("mrst_resetn", 32'(bus.fifo_resetn), 0);
    chk("mrst_empty", 32'(bus.empty), 1);
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) pdata[i] = W'(16'h2000 + i);
    step(4'b1111, 1'b0);
    chk("post_rst_grant", 32'(m_last), 0);
    step(4'b1111, 1'b0);
    step('0, 1'b1);
    step('0, 1'b1);
    step('0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
